hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
Pipeline sequencing controller for the 5-stage ARM core (IF/ID/EX/MEM/WB).
- Drives the PC enable, IF/ID enable and flush, and the control-unit mux NOP select.
- Generates operand forwarding selects for the three register read ports.
- Tracks destination-register shadow state for EX, MEM and WB internally, so its only inputs are the ID-stage decode fields plus branch and halt requests.
- Also provides a debug halt/drain handshake.

Parameters:
- DRAIN_CYCLES, 3, cycles spent draining EX/MEM/WB after fetch stops on halt request (1..7).
- REG_ADDR_W, 4, register specifier width (R0..R15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rn / id_rm / id_rs  in  REG_ADDR_W each  ID-stage source specifiers (ports A/B/C; C = store data)
- id_use_rn / id_use_rm / id_use_rs  in  1 each  source actually read by ID instruction
- id_rd  in  REG_ADDR_W  ID-stage destination
- id_reg_write  in  1  ID instruction writes id_rd (post cond-check)
- id_is_load  in  1  ID instruction is LDR/LDRB
- id_branch_taken  in  1  branch/BL resolved taken in ID
- halt_req  in  1  debug halt request, level
- pc_enable  out  1  PC register load enable
- if_id_enable  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads NOP (0x00000000) this edge
- nop_select  out  1  cu_mux forces all control outputs to 0 (bubble into ID/EX)
- fwd_a_sel / fwd_b_sel / fwd_c_sel  out  2 each  00 regfile, 01 EX result, 10 MEM result, 11 WB result
- halt_ack  out  1  pipeline empty and frozen
- stalled  out  1  load-use stall active this cycle

Behaviour:
- States: RUN, DRAIN, HALTED. Reset (async): state=RUN, drain counter=0, all shadow valid/we bits=0.
- Output reset values: pc_enable=1, if_id_enable=1, if_id_flush=0, nop_select=0, fwd_*=00, halt_ack=0, stalled=0.
- Shadow pipeline, updated every edge:
  - EX shadow <= {id_rd, id_reg_write & ~nop_select, id_is_load & ~nop_select}.
  - MEM shadow <= EX shadow.
  - WB shadow <= MEM shadow.
- Match(X, stage) = use_X & stage.we & (X == stage.rd).
- Forward priority per port: EX > MEM > WB. Exception: an EX match whose EX shadow is a load yields no forward (stall case).
- R15 sources never forward (fwd=00) and never stall.
- Load-use stall (RUN only): any port matches an EX-shadow load → stalled=1, pc_enable=0, if_id_enable=0, nop_select=1 for exactly 1 cycle. Next cycle the load sits in MEM and the port forwards 10.
- Branch (RUN only, no stall): id_branch_taken=1 → if_id_flush=1, pc_enable=1 (PC loads target), nop_select=0. One bubble.
- Stall and branch in the same cycle: stall wins, branch ignored; the ID instruction re-presents next cycle.
- halt_req in RUN: if a stall is active, complete it first. Otherwise enter DRAIN:
  - pc_enable=0, if_id_enable=0, nop_select=1; counter loads DRAIN_CYCLES-1.
  - A taken branch in the entry cycle still flushes IF/ID.
- DRAIN: counter decrements each cycle; at 0 → HALTED.
  - halt_req dropping in DRAIN → RUN next cycle (IF/ID contents preserved).
- HALTED: halt_ack=1; pc_enable=0, if_id_enable=0, nop_select=1. halt_req=0 → RUN, with halt_ack low that same edge.
- Reset mid-DRAIN or mid-stall: immediate return to RUN with shadows cleared.
- Forwarding selects are combinational from shadows and ID fields; all other outputs are combinational from state and inputs. Zero-cycle latency.

Optional Feature:
HAZARD_FORWARDING_EN.
- Defined: forwarding as above; stall only on load-use.
- Undefined: fwd_* tied 00. Any source match against EX, MEM or WB shadow stalls the pipeline (same stall signalling), repeating until no match remains (up to 3 cycles).

Decomposition:
- Package arm_pipe_pkg:
  - state enum (RUN/DRAIN/HALTED).
  - forward-select constants FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
  - NOP instruction constant.
  - shadow-stage struct {rd, we, load}.
- Sub-module fwd_select: one instance per read port, computing the 2-bit select from specifier, use bit and three shadows.

Test Plan:
- ADD R5,R0,R3 directly after ANDS R0,R1,#0 → fwd_a_sel=01 that cycle, no stall. After 2 independent instructions instead → fwd_a_sel=11.
- LDRB R2,[R1,R0] then STR R2,[R10,#0] → stalled=1, pc_enable=0, nop_select=1 for 1 cycle. Next cycle fwd_c_sel=10.
- BNE taken (id_branch_taken=1) → if_id_flush=1 one cycle, pc_enable=1. Combined with load-use stall → flush=0, stalled=1.
- halt_req=1 in steady RUN → DRAIN, halt_ack=1 after exactly 3 cycles. Deassert → RUN, pc_enable=1 next cycle.
- Reset asserted asynchronously mid-DRAIN → all outputs at reset values before the next edge; shadow we=0, so no forward for the following instruction.
- HAZARD_FORWARDING_EN undefined, ADD R5,R0,R3 after ANDS R0,… → stall 3 cycles, fwd_*=00 throughout.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the 5-stage ARM pipeline sequencing logic.
package arm_pipe_pkg;

    // Shadow rd fields are stored zero-extended to this width.
    localparam int REG_ADDR_W_MAX = 8;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        DRAIN  = ST_DRAIN,
        HALTED = ST_HALTED
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [REG_ADDR_W_MAX-1:0] rd;
        logic                      we;
        logic                      load;
    } shadow_t;

    function automatic logic [REG_ADDR_W_MAX-1:0] rd_ext(input logic [REG_ADDR_W_MAX-1:0] rd);
        return rd;
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// ID-stage decode fields in, pipeline sequencing controls out.
interface hazard_sequencer_if #(
    parameter int REG_ADDR_W = 4
);
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic [REG_ADDR_W-1:0] id_rs;
    logic                  id_use_rn;
    logic                  id_use_rm;
    logic                  id_use_rs;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  id_branch_taken;
    logic                  halt_req;

    logic                  pc_enable;
    logic                  if_id_enable;
    logic                  if_id_flush;
    logic                  nop_select;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [1:0]            fwd_c_sel;
    logic                  halt_ack;
    logic                  stalled;

    modport master (
        output id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
               id_rd, id_reg_write, id_is_load, id_branch_taken, halt_req,
        input  pc_enable, if_id_enable, if_id_flush, nop_select,
               fwd_a_sel, fwd_b_sel, fwd_c_sel, halt_ack, stalled
    );

    modport slave (
        input  id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
               id_rd, id_reg_write, id_is_load, id_branch_taken, halt_req,
        output pc_enable, if_id_enable, if_id_flush, nop_select,
               fwd_a_sel, fwd_b_sel, fwd_c_sel, halt_ack, stalled
    );
endinterface

// File: rtl/fwd_select.sv
// Per-read-port forward select and stall request from the EX/MEM/WB shadows.
// HAZARD_FORWARDING_EN: forward EX>MEM>WB; otherwise any match requests a stall.
module fwd_select
    import arm_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  shadow_t               ex,
    input  shadow_t               mem,
    input  shadow_t               wb,
    output logic [1:0]            sel,
    output logic                  stall_hit
);
    logic [REG_ADDR_W_MAX-1:0] src_ext;
    logic live;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;
    logic load_hit;

    assign src_ext  = REG_ADDR_W_MAX'(src);
    // R15 reads the PC path, never a pipeline result.
    assign live     = use_src & (src != '1);
    assign hit_ex   = live & ex.we  & (ex.rd  == src_ext);
    assign hit_mem  = live & mem.we & (mem.rd == src_ext);
    assign hit_wb   = live & wb.we  & (wb.rd  == src_ext);
    assign load_hit = hit_ex & ex.load;

`ifdef HAZARD_FORWARDING_EN
    assign stall_hit = load_hit;

    always_comb begin
        sel = FWD_RF;
        if (hit_ex) begin
            sel = ex.load ? FWD_RF : FWD_EX;
        end else if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end
`else
    assign stall_hit = load_hit | hit_ex | hit_mem | hit_wb;
    assign sel       = FWD_RF;
`endif

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: load-use stall, branch flush, forwarding, debug halt/drain.
// HAZARD_FORWARDING_EN selects forwarding; undefined, every RAW match stalls.
module hazard_sequencer
    import arm_pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    hazard_sequencer_if.slave bus
);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] drain_cnt;
    logic [2:0] drain_nx;
    shadow_t    ex_sh;
    shadow_t    mem_sh;
    shadow_t    wb_sh;

    logic hit_a;
    logic hit_b;
    logic hit_c;
    logic stall;
    logic pc_en;
    logic ifid_en;
    logic flush;
    logic nop;
    logic ack;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src(bus.id_rn), .use_src(bus.id_use_rn),
        .ex(ex_sh), .mem(mem_sh), .wb(wb_sh),
        .sel(bus.fwd_a_sel), .stall_hit(hit_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src(bus.id_rm), .use_src(bus.id_use_rm),
        .ex(ex_sh), .mem(mem_sh), .wb(wb_sh),
        .sel(bus.fwd_b_sel), .stall_hit(hit_b)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_c (
        .src(bus.id_rs), .use_src(bus.id_use_rs),
        .ex(ex_sh), .mem(mem_sh), .wb(wb_sh),
        .sel(bus.fwd_c_sel), .stall_hit(hit_c)
    );

    assign stall = (state == RUN) & (hit_a | hit_b | hit_c);

    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        flush    = 1'b0;
        nop      = 1'b0;
        ack      = 1'b0;
        state_nx = state;
        drain_nx = drain_cnt;
        case (state)
            RUN: begin
                // A pending stall finishes before a halt or branch is honoured.
                if (stall) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    nop     = 1'b1;
                end else if (bus.halt_req) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    nop      = 1'b1;
                    flush    = bus.id_branch_taken;
                    state_nx = DRAIN;
                    drain_nx = DRAIN_INIT;
                end else if (bus.id_branch_taken) begin
                    flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                nop     = 1'b1;
                if (!bus.halt_req) begin
                    state_nx = RUN;
                end else if (drain_cnt == '0) begin
                    state_nx = HALTED;
                end else begin
                    drain_nx = drain_cnt - 3'd1;
                end
            end
            HALTED: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                nop     = 1'b1;
                ack     = 1'b1;
                if (!bus.halt_req) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            ex_sh     <= '0;
            mem_sh    <= '0;
            wb_sh     <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
            ex_sh     <= '{rd:   REG_ADDR_W_MAX'(bus.id_rd),
                           we:   bus.id_reg_write & ~nop,
                           load: bus.id_is_load & ~nop};
            mem_sh    <= ex_sh;
            wb_sh     <= mem_sh;
        end
    end

    assign bus.pc_enable    = pc_en;
    assign bus.if_id_enable = ifid_en;
    assign bus.if_id_flush  = flush;
    assign bus.nop_select   = nop;
    assign bus.halt_ack     = ack;
    assign bus.stalled      = stall;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed table-driven bench for hazard_sequencer, both HAZARD_FORWARDING_EN builds.
`timescale 1ns/1ps
module tb_hazard_sequencer;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Cycles a load-use hazard holds ID: one with forwarding, through WB without.
    localparam int LU_N = FWD ? 1 : 3;

    // Expected control bits {pc_enable, if_id_enable, if_id_flush, nop_select, halt_ack, stalled}
    localparam logic [5:0] C_RUN    = 6'b110000;
    localparam logic [5:0] C_BR     = 6'b111000;
    localparam logic [5:0] C_STL    = 6'b000101;
    localparam logic [5:0] C_HOLD   = 6'b000100;
    localparam logic [5:0] C_HOLDFL = 6'b001100;
    localparam logic [5:0] C_HALT   = 6'b000110;

    typedef struct {
        string      name;
        logic [3:0] rn, rm, rs, rd;
        logic [2:0] uses;
        logic       we, ld, br, halt;
        logic [5:0] ctl;
        logic [1:0] fa, fb, fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_sequencer_if #(.REG_ADDR_W(4)) bus ();

    hazard_sequencer #(.DRAIN_CYCLES(3), .REG_ADDR_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic vec_t v(input string name,
                               input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                               input logic [2:0] uses, input logic [3:0] rd,
                               input logic we, input logic ld, input logic br, input logic halt,
                               input logic [5:0] ctl,
                               input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fc);
        vec_t t;
        t.name = name; t.rn = rn; t.rm = rm; t.rs = rs; t.uses = uses; t.rd = rd;
        t.we = we; t.ld = ld; t.br = br; t.halt = halt;
        t.ctl = ctl; t.fa = fa; t.fb = fb; t.fc = fc;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        bus.id_rn           = t.rn;
        bus.id_rm           = t.rm;
        bus.id_rs           = t.rs;
        bus.id_use_rn       = t.uses[2];
        bus.id_use_rm       = t.uses[1];
        bus.id_use_rs       = t.uses[0];
        bus.id_rd           = t.rd;
        bus.id_reg_write    = t.we;
        bus.id_is_load      = t.ld;
        bus.id_branch_taken = t.br;
        bus.halt_req        = t.halt;
    endtask

    task automatic check(input vec_t t);
        logic [5:0] got_ctl;
        got_ctl = {bus.pc_enable, bus.if_id_enable, bus.if_id_flush,
                   bus.nop_select, bus.halt_ack, bus.stalled};
        checks++;
        if ({got_ctl, bus.fwd_a_sel, bus.fwd_b_sel, bus.fwd_c_sel} !==
            {t.ctl, t.fa, t.fb, t.fc}) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b/%b/%b, want ctl=%b fwd=%b/%b/%b",
                     t.name, got_ctl, bus.fwd_a_sel, bus.fwd_b_sel, bus.fwd_c_sel,
                     t.ctl, t.fa, t.fb, t.fc);
        end
    endtask

    task automatic step(input vec_t t);
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
        check(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = v("idle", 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);

        reset = 1'b1;
        drive(idle);
        #2;
        idle.name = "reset_hold";
        check(idle);
        #10;
        reset = 1'b0;

        //          name            rn  rm  rs  uses    rd we ld br ht ctl       fa fb fc
        tbl.push_back(v("reset_state",  0,  0,  0, 3'b000,  0, 0, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("ands_r0",      1,  0,  0, 3'b100,  0, 1, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("mov_r7_nouse", 0,  0,  0, 3'b000,  7, 1, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("write_r15",    0,  0,  0, 3'b000, 15, 1, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("r15_src",     15,  9,  3, 3'b111,  8, 0, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("branch",       2,  0,  0, 3'b100,  0, 0, 0, 1, 0, C_BR,     0, 0, 0));
        tbl.push_back(v("after_branch", 1,  0,  0, 3'b100,  0, 0, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("halt_entry_br",0,  0,  0, 3'b000,  0, 0, 0, 1, 1, C_HOLDFL, 0, 0, 0));
        tbl.push_back(v("drain_1",      0,  0,  0, 3'b000,  0, 0, 0, 0, 1, C_HOLD,   0, 0, 0));
        tbl.push_back(v("drain_2",      0,  0,  0, 3'b000,  0, 0, 0, 0, 1, C_HOLD,   0, 0, 0));
        tbl.push_back(v("drain_3",      0,  0,  0, 3'b000,  0, 0, 0, 0, 1, C_HOLD,   0, 0, 0));
        tbl.push_back(v("halted",       0,  0,  0, 3'b000,  0, 0, 0, 0, 1, C_HALT,   0, 0, 0));
        tbl.push_back(v("unhalt",       0,  0,  0, 3'b000,  0, 0, 0, 0, 0, C_HALT,   0, 0, 0));
        tbl.push_back(v("run_again",    0,  0,  0, 3'b000,  0, 0, 0, 0, 0, C_RUN,    0, 0, 0));
        tbl.push_back(v("halt2_entry",  0,  0,  0, 3'b000,  0, 0, 0, 0, 1, C_HOLD,   0, 0, 0));
        tbl.push_back(v("halt2_drain",  0,  0,  0, 3'b000,  0, 0, 0, 0, 1, C_HOLD,   0, 0, 0));
        tbl.push_back(v("drain_abort",  0,  0,  0, 3'b000,  0, 0, 0, 0, 0, C_HOLD,   0, 0, 0));
        tbl.push_back(v("resumed",      0,  0,  0, 3'b000,  0, 0, 0, 0, 0, C_RUN,    0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // ANDS R0 then ADD R5,R0,R3 back to back.
        step(v("h1_ands", 1, 0, 0, 3'b100, 0, 1, 0, 0, 0, C_RUN, 0, 0, 0));
        for (int i = 0; i < (FWD ? 0 : 3); i++)
            step(v("h1_add_stall", 0, 3, 0, 3'b110, 5, 1, 0, 0, 0, C_STL, 0, 0, 0));
        step(v("h1_add_ex", 0, 3, 0, 3'b110, 5, 1, 0, 0, 0, C_RUN, FWD ? 2'b01 : 2'b00, 0, 0));

        // Same pair with two independent instructions between.
        step(v("h2_ands",  1, 0, 0, 3'b100,  0, 1, 0, 0, 0, C_RUN, 0, 0, 0));
        step(v("h2_ind1",  0, 0, 0, 3'b000,  9, 1, 0, 0, 0, C_RUN, 0, 0, 0));
        step(v("h2_ind2",  0, 0, 0, 3'b000, 10, 1, 0, 0, 0, C_RUN, 0, 0, 0));
        for (int i = 0; i < (FWD ? 0 : 1); i++)
            step(v("h2_add_stall", 0, 3, 0, 3'b110, 5, 1, 0, 0, 0, C_STL, 0, 0, 0));
        step(v("h2_add_wb", 0, 3, 0, 3'b110, 5, 1, 0, 0, 0, C_RUN, FWD ? 2'b11 : 2'b00, 0, 0));

        // LDRB R2,[R1,R0] then STR R2,[R10,#0]; R10 is still in WB under forwarding.
        step(v("h3_ldrb", 1, 0, 0, 3'b110, 2, 1, 1, 0, 0, C_RUN, 0, 0, 0));
        for (int i = 0; i < LU_N; i++)
            step(v("h3_str_stall", 10, 0, 2, 3'b101, 0, 0, 0, 0, 0, C_STL, FWD ? 2'b11 : 2'b00, 0, 0));
        step(v("h3_str_mem", 10, 0, 2, 3'b101, 0, 0, 0, 0, 0, C_RUN, 0, 0, FWD ? 2'b10 : 2'b00));

        // Taken branch colliding with a load-use stall.
        step(v("h4_ldr_r4", 0, 0, 0, 3'b000, 4, 1, 1, 0, 0, C_RUN, 0, 0, 0));
        for (int i = 0; i < LU_N; i++)
            step(v("h4_br_stall", 4, 0, 0, 3'b100, 0, 0, 0, 1, 0, C_STL, 0, 0, 0));
        step(v("h4_br_flush", 4, 0, 0, 3'b100, 0, 0, 0, 1, 0, C_BR, FWD ? 2'b10 : 2'b00, 0, 0));

        // Halt request arriving during a load-use stall.
        step(v("h5_ldr_r6", 0, 0, 0, 3'b000, 6, 1, 1, 0, 0, C_RUN, 0, 0, 0));
        for (int i = 0; i < LU_N; i++)
            step(v("h5_halt_stall", 6, 0, 0, 3'b100, 1, 1, 0, 0, 1, C_STL, 0, 0, 0));
        step(v("h5_halt_entry", 6, 0, 0, 3'b100, 1, 1, 0, 0, 1, C_HOLD, FWD ? 2'b10 : 2'b00, 0, 0));
        step(v("h5_drain",   0, 0, 0, 3'b000, 0, 0, 0, 0, 1, C_HOLD, 0, 0, 0));
        step(v("h5_abort",   0, 0, 0, 3'b000, 0, 0, 0, 0, 0, C_HOLD, 0, 0, 0));
        step(v("h5_resumed", 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, C_RUN,  0, 0, 0));

        // Asynchronous reset mid-DRAIN while R3 sits in the MEM shadow.
        step(v("h6_wr_r3", 0, 0, 0, 3'b000, 3, 1, 0, 0, 0, C_RUN,  0, 0, 0));
        step(v("h6_entry", 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, C_HOLD, 0, 0, 0));
        step(v("h6_drain", 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, C_HOLD, 0, 0, 0));
        #1;
        reset = 1'b1;
        drive(v("h6_add", 3, 0, 0, 3'b100, 5, 1, 0, 0, 0, C_RUN, 0, 0, 0));
        #1;
        check(v("h6_in_reset", 3, 0, 0, 3'b100, 5, 1, 0, 0, 0, C_RUN, 0, 0, 0));
        #1;
        reset = 1'b0;
        step(v("h6_after_reset", 3, 0, 0, 3'b100, 5, 1, 0, 0, 0, C_RUN, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
